// File: rtl/gpcore_exe_pkg.sv
// Shared types for the execute stage: ALU function codes, FSM states, request payload.
package gpcore_exe_pkg;

  localparam int unsigned ALU_FN_W = 4;
  localparam int unsigned PCSEL_W  = 2;

  typedef enum logic [ALU_FN_W-1:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    SLL   = 4'd2,
    SLT   = 4'd3,
    SLTU  = 4'd4,
    XOR   = 4'd5,
    SRL   = 4'd6,
    SRA   = 4'd7,
    OR    = 4'd8,
    AND   = 4'd9,
    MUL   = 4'd10,
    MULHU = 4'd11
  } alu_fn_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } exe_state_e;

  // Width-independent part of the issue payload; operands, pc, imm and rd
  // follow the module parameters and travel as separate ports.
  typedef struct packed {
    alu_fn_e              alu_fn;
    logic                 btype;
    logic                 bneq;
    logic [PCSEL_W-1:0]   pcselect;
    logic                 we;
    logic                 fn;
  } exe_req_t;

  // True for the ops that go through the iterative multiplier.
  function automatic logic is_mul_fn(alu_fn_e f);
    return (f == MUL) || (f == MULHU);
  endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add unsigned multiplier, MUL_STEP multiplier bits per cycle.
module exe_mul_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*XLEN-1:0] prod_o
);

  localparam int unsigned STEPS = XLEN / MUL_STEP;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned SW    = XLEN + MUL_STEP;

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    prod_d;
  logic [XLEN-1:0]  mcand_q;
  logic [SW-1:0]    partial_c;
  logic [SW-1:0]    sum_c;

  // One shift-add step: low half of prod_q holds the remaining multiplier bits.
  always_comb begin
    partial_c = SW'(mcand_q) * SW'(prod_q[MUL_STEP-1:0]);
    sum_c     = SW'(prod_q[PW-1:XLEN]) + partial_c;
    prod_d    = PW'({sum_c, prod_q[XLEN-1:0]} >> MUL_STEP);
  end

  // Step counter and product register; done pulses for one cycle after the last step.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
    end else if (abort_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      cnt_q   <= CNT_W'(STEPS);
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      prod_q  <= {{XLEN{1'b0}}, b_i};
      mcand_q <= a_i;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done_q <= 1'b1;
        end
      end else begin
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign prod_o = prod_q;

endmodule

// File: rtl/exe_stage_pipe.sv
// Execute stage: ALU, branch resolve, iterative MUL, valid/ready output register with flush.
module exe_stage_pipe
  import gpcore_exe_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned MUL_EN   = 1,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_alu_fn,
  input  logic [XLEN-1:0]    in_op_a,
  input  logic [XLEN-1:0]    in_op_b,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_b_imm,
  input  logic               in_btype,
  input  logic               in_bneq,
  input  logic [1:0]         in_pcselect,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_we,
  input  logic               in_fn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_res,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_we,
  output logic               out_fn,
  output logic [1:0]         out_pcselect,
  output logic               out_btaken,
  output logic [XLEN-1:0]    out_b_target
);

  localparam int unsigned SHW = $clog2(XLEN);

  exe_state_e           state_q;
  logic                 out_valid_q;
  logic [XLEN-1:0]      out_res_q;
  logic [RADDR_W-1:0]   out_rd_q;
  logic                 out_we_q;
  logic                 out_fn_q;
  logic [1:0]           out_pcselect_q;
  logic                 out_btaken_q;
  logic [XLEN-1:0]      out_b_target_q;
  logic                 mul_hi_q;

  exe_req_t             req_c;
  logic [SHW-1:0]       shamt_c;
  logic [XLEN-1:0]      alu_res_c;
  logic                 btaken_c;
  logic [XLEN-1:0]      target_c;
  logic                 is_mul_c;
  logic                 accept_c;

  logic                 mul_busy;
  logic                 mul_done;
  logic [2*XLEN-1:0]    mul_prod;

  // Pack the control payload of the incoming op.
  always_comb begin
    req_c          = '0;
    req_c.alu_fn   = alu_fn_e'(in_alu_fn);
    req_c.btype    = in_btype;
    req_c.bneq     = in_bneq;
    req_c.pcselect = in_pcselect;
    req_c.we       = in_we;
    req_c.fn       = in_fn;
  end

  assign in_ready = (state_q == IDLE) & (~out_valid_q | out_ready) & ~flush;
  assign accept_c = in_valid & in_ready;
  assign is_mul_c = (MUL_EN != 0) && is_mul_fn(req_c.alu_fn);
  assign shamt_c  = in_op_b[SHW-1:0];

  // Single-cycle ALU; MUL/MULHU and unknown codes give 0 here.
  always_comb begin
    alu_res_c = '0;
    case (req_c.alu_fn)
      ADD:     alu_res_c = in_op_a + in_op_b;
      SUB:     alu_res_c = in_op_a - in_op_b;
      SLL:     alu_res_c = in_op_a << shamt_c;
      SLT:     alu_res_c = XLEN'($signed(in_op_a) < $signed(in_op_b));
      SLTU:    alu_res_c = XLEN'(in_op_a < in_op_b);
      XOR:     alu_res_c = in_op_a ^ in_op_b;
      SRL:     alu_res_c = in_op_a >> shamt_c;
      SRA:     alu_res_c = $unsigned($signed(in_op_a) >>> shamt_c);
      OR:      alu_res_c = in_op_a | in_op_b;
      AND:     alu_res_c = in_op_a & in_op_b;
      default: alu_res_c = '0;
    endcase
  end

  // Branch compare and target for fetch redirect.
  always_comb begin
    btaken_c = req_c.btype & (req_c.bneq ? (in_op_a != in_op_b) : (in_op_a == in_op_b));
    target_c = in_pc + in_b_imm;
  end

  if (MUL_EN != 0) begin : g_mul
    exe_mul_iter #(
      .XLEN     (XLEN),
      .MUL_STEP (MUL_STEP)
    ) u_mul (
      .clk     (clk),
      .nrst    (nrst),
      .start_i (accept_c & is_mul_c),
      .abort_i (flush),
      .a_i     (in_op_a),
      .b_i     (in_op_b),
      .busy_o  (mul_busy),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // Stage FSM and output register; side-band fields load at accept, result at completion.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      out_valid_q    <= 1'b0;
      out_res_q      <= '0;
      out_rd_q       <= '0;
      out_we_q       <= 1'b0;
      out_fn_q       <= 1'b0;
      out_pcselect_q <= '0;
      out_btaken_q   <= 1'b0;
      out_b_target_q <= '0;
      mul_hi_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            out_rd_q       <= in_rd;
            out_we_q       <= req_c.we;
            out_fn_q       <= req_c.fn;
            out_pcselect_q <= req_c.pcselect;
            out_btaken_q   <= btaken_c;
            out_b_target_q <= target_c;
            if (is_mul_c) begin
              state_q     <= MUL_BUSY;
              out_valid_q <= 1'b0;
              mul_hi_q    <= (req_c.alu_fn == MULHU);
            end else begin
              out_res_q   <= alu_res_c;
              out_valid_q <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL_BUSY: begin
          // Leaving on a lost multiplier (not busy) keeps the stage from wedging.
          if (mul_done || !mul_busy) begin
            out_res_q   <= mul_hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
            out_valid_q <= mul_done;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_res      = out_res_q;
  assign out_rd       = out_rd_q;
  assign out_we       = out_we_q;
  assign out_fn       = out_fn_q;
  assign out_pcselect = out_pcselect_q;
  assign out_btaken   = out_btaken_q;
  assign out_b_target = out_b_target_q;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed bench for exe_stage_pipe with default parameters (XLEN=32, MUL_STEP=1).
module tb_exe_stage_pipe;
  import gpcore_exe_pkg::*;

  logic        clk;
  logic        nrst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_fn;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic [31:0] in_pc;
  logic [31:0] in_b_imm;
  logic        in_btype;
  logic        in_bneq;
  logic [1:0]  in_pcselect;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        in_fn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_fn;
  logic [1:0]  out_pcselect;
  logic        out_btaken;
  logic [31:0] out_b_target;

  int checks;
  int errors;

  exe_stage_pipe dut (
    .clk          (clk),
    .nrst         (nrst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_alu_fn    (in_alu_fn),
    .in_op_a      (in_op_a),
    .in_op_b      (in_op_b),
    .in_pc        (in_pc),
    .in_b_imm     (in_b_imm),
    .in_btype     (in_btype),
    .in_bneq      (in_bneq),
    .in_pcselect  (in_pcselect),
    .in_rd        (in_rd),
    .in_we        (in_we),
    .in_fn        (in_fn),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res      (out_res),
    .out_rd       (out_rd),
    .out_we       (out_we),
    .out_fn       (out_fn),
    .out_pcselect (out_pcselect),
    .out_btaken   (out_btaken),
    .out_b_target (out_b_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    in_alu_fn = fn;
    in_op_a   = a;
    in_op_b   = b;
  endtask

  task automatic test_reset();
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_alu_fn = '0; in_op_a = '0; in_op_b = '0;
    in_pc = '0; in_b_imm = '0; in_btype = 1'b0; in_bneq = 1'b0; in_pcselect = '0;
    in_rd = '0; in_we = 1'b0; in_fn = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
    checks++; if (out_res !== 32'h0) begin errors++; $display("FAIL reset out_res: got %h exp 0", out_res); end
    checks++; if (out_b_target !== 32'h0 || out_btaken !== 1'b0) begin errors++; $display("FAIL reset branch: got %h/%b exp 0/0", out_b_target, out_btaken); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
    nrst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset ready/valid: got %b/%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_add_wrap();
    out_ready = 1'b1;
    set_op(ADD, 32'hFFFF_FFFF, 32'h1);
    in_rd = 5'd3; in_we = 1'b1; in_fn = 1'b1; in_pcselect = 2'd2;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add in_ready: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add out_valid: got %b exp 1", out_valid); end
    checks++; if (out_res !== 32'h0) begin errors++; $display("FAIL add out_res: got %h exp 00000000", out_res); end
    checks++; if (out_rd !== 5'd3 || out_we !== 1'b1 || out_fn !== 1'b1 || out_pcselect !== 2'd2) begin
      errors++; $display("FAIL add passthru: got rd=%0d we=%b fn=%b pcsel=%0d exp 3/1/1/2", out_rd, out_we, out_fn, out_pcselect);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add valid_drop: got %b exp 0", out_valid); end
    in_rd = '0; in_we = 1'b0; in_fn = 1'b0; in_pcselect = '0;
  endtask

  logic [31:0] br_a   [4];
  logic [31:0] br_b   [4];
  logic [31:0] br_res [4];
  logic        br_bt  [4];
  logic        br_ne  [4];
  logic        br_tk  [4];

  task automatic test_branch();
    br_a   = '{32'd5, 32'd5, 32'd7, 32'd7};
    br_b   = '{32'd5, 32'd6, 32'd7, 32'd7};
    br_res = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    br_bt  = '{1'b1, 1'b1, 1'b1, 1'b0};
    br_ne  = '{1'b1, 1'b1, 1'b0, 1'b0};
    br_tk  = '{1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    in_pc = 32'h100; in_b_imm = 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) begin
      set_op(SUB, br_a[i], br_b[i]);
      in_btype = br_bt[i]; in_bneq = br_ne[i];
      tick();
      checks++; if (out_valid !== 1'b1 || out_btaken !== br_tk[i]) begin
        errors++; $display("FAIL branch[%0d] taken: got v=%b t=%b exp v=1 t=%b", i, out_valid, out_btaken, br_tk[i]);
      end
      checks++; if (out_b_target !== 32'h0000_00F0 || out_res !== br_res[i]) begin
        errors++; $display("FAIL branch[%0d] target/res: got %h/%h exp 000000f0/%h", i, out_b_target, out_res, br_res[i]);
      end
    end
    in_valid = 1'b0; in_btype = 1'b0; in_bneq = 1'b0; in_pc = '0; in_b_imm = '0;
    tick();
  endtask

  logic [3:0]  alu_fn_v [11];
  logic [31:0] alu_a_v  [11];
  logic [31:0] alu_b_v  [11];
  logic [31:0] alu_r_v  [11];

  task automatic test_alu_ops();
    alu_fn_v = '{SLL, SRL, SRA, SRA, SLT, SLTU, XOR, OR, AND, SUB, 4'hF};
    alu_a_v  = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h1, 32'h1,
                 32'hF0F0, 32'hF000, 32'hFF0F, 32'h0, 32'h5};
    alu_b_v  = '{32'h24, 32'd31, 32'd4, 32'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFF00, 32'h000F, 32'h0FF0, 32'h1, 32'h6};
    alu_r_v  = '{32'h10, 32'h1, 32'hF800_0000, 32'h2000_0000, 32'h0, 32'h1,
                 32'h0FF0, 32'hF00F, 32'h0F00, 32'hFFFF_FFFF, 32'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_op(alu_fn_v[i], alu_a_v[i], alu_b_v[i]);
      tick();
      checks++; if (out_valid !== 1'b1 || out_res !== alu_r_v[i]) begin
        errors++; $display("FAIL alu[%0d] fn=%0d: got v=%b res=%h exp v=1 res=%h", i, alu_fn_v[i], out_valid, out_res, alu_r_v[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mul(input string nm, input logic [3:0] fn, input logic [31:0] exp_res);
    int bad_cycles;
    out_ready = 1'b1;
    set_op(fn, 32'h1234_5678, 32'h10);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready: got %b exp 1", nm, in_ready); end
    tick();
    in_valid = 1'b0;
    bad_cycles = 0;
    for (int c = 0; c < 32; c++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad_cycles++;
      tick();
    end
    checks++; if (bad_cycles != 0) begin errors++; $display("FAIL %s busy_window: got %0d bad cycles exp 0", nm, bad_cycles); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL %s at_plus32: got v=%b r=%b exp 0/0", nm, out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_res !== exp_res) begin
      errors++; $display("FAIL %s result: got v=%b res=%h exp v=1 res=%h", nm, out_valid, out_res, exp_res);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s valid_drop: got %b exp 0", nm, out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_op(SUB, 32'd10, 32'd1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp first_ready: got %b exp 1", in_ready); end
    tick();
    set_op(SUB, 32'd20, 32'd2);
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || out_res !== 32'd9 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp hold[%0d]: got v=%b res=%h r=%b exp 1/00000009/0", c, out_valid, out_res, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release_ready: got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_res !== 32'd18) begin errors++; $display("FAIL bp second: got v=%b res=%h exp 1/00000012", out_valid, out_res); end
    set_op(SUB, 32'd30, 32'd3);
    tick();
    checks++; if (out_valid !== 1'b1 || out_res !== 32'd27) begin errors++; $display("FAIL bp third: got v=%b res=%h exp 1/0000001b", out_valid, out_res); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drain: got %b exp 0", out_valid); end
  endtask

  task automatic test_flush_mul();
    int stray;
    out_ready = 1'b1;
    set_op(MUL, 32'd3, 32'd4);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    set_op(ADD, 32'd7, 32'd7);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush ready_during: got %b exp 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush after: got v=%b r=%b exp 0/1", out_valid, in_ready); end
    set_op(ADD, 32'd2, 32'd3);
    tick();
    checks++; if (out_valid !== 1'b1 || out_res !== 32'd5) begin errors++; $display("FAIL flush add: got v=%b res=%h exp 1/00000005", out_valid, out_res); end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush consumed: got %b exp 0", out_valid); end
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL flush stray_result: got %0d valid cycles exp 0", stray); end
  endtask

  task automatic test_reset_mid_mul();
    int stray;
    out_ready = 1'b1;
    in_pc = 32'h200; in_b_imm = 32'h4; in_rd = 5'd7; in_we = 1'b1;
    set_op(MUL, 32'h1234_5678, 32'h10);
    tick();
    in_valid = 1'b0; in_pc = '0; in_b_imm = '0; in_rd = '0; in_we = 1'b0;
    repeat (5) tick();
    nrst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_res !== 32'h0 || out_rd !== 5'd0 || out_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid outputs: got v=%b res=%h rd=%0d we=%b exp all 0", out_valid, out_res, out_rd, out_we);
    end
    checks++; if (out_b_target !== 32'h0 || out_btaken !== 1'b0 || out_pcselect !== 2'd0 || out_fn !== 1'b0) begin
      errors++; $display("FAIL rst_mid branch: got tgt=%h t=%b exp 0/0", out_b_target, out_btaken);
    end
    tick(); tick();
    nrst = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid partial: got %0d bad cycles exp 0", stray); end
    set_op(SLT, 32'hFFFF_FFFF, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_res !== 32'h1) begin errors++; $display("FAIL rst_mid slt: got v=%b res=%h exp 1/00000001", out_valid, out_res); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_wrap();
    test_branch();
    test_alu_ops();
    test_mul("mul", MUL, 32'h2345_6780);
    test_mul("mulhu", MULHU, 32'h1);
    test_back_to_back();
    test_flush_mul();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
